// File: rtl/bundle_issue_scheduler_pkg.sv
// Shared types and helpers for the bundle issue scheduler.
// Widths for address, instruction, bundle, PID, TID and major-ID counter
// live here so the queue, interface and top all agree on one entry layout.
package bundle_issue_scheduler_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INSN_W   = 32;
  localparam int unsigned BUNDLE_W = 4 * INSN_W;
  localparam int unsigned PID_W    = 32;
  localparam int unsigned TID_W    = 64;
  localparam int unsigned CNT_W    = 64;

  // Length code = instruction count minus one.
  localparam logic [1:0] LEN_1 = 2'b00;
  localparam logic [1:0] LEN_2 = 2'b01;
  localparam logic [1:0] LEN_3 = 2'b10;
  localparam logic [1:0] LEN_4 = 2'b11;

  typedef struct packed {
    logic [BUNDLE_W-1:0] bundle;
    logic [ADDR_W-1:0]   addr;
    logic [1:0]          len;
    logic                is64;
    logic [PID_W-1:0]    pid;
    logic [TID_W-1:0]    tid;
  } q_entry_t;

  // A bundle of len+1 instructions needs decoders 1..len+1 ready.
  function automatic logic dec_ready_ok(input logic [1:0] len, input logic [3:0] rdy);
    logic ok;
    case (len)
      LEN_1:   ok = rdy[0];
      LEN_2:   ok = &rdy[1:0];
      LEN_3:   ok = &rdy[2:0];
      LEN_4:   ok = &rdy[3:0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Saturating 32-bit increment for statistics counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) r = v;
    else                    r = v + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/bundle_issue_scheduler_if.sv
// Fetch/issue signal bundle of the scheduler. The slave modport is the
// scheduler's view; master is the fetch/parser side (or a testbench).
// Statistics outputs exist only when ISSUE_STATS_EN is defined.
interface bundle_issue_scheduler_if;
  import bundle_issue_scheduler_pkg::*;

  logic                fetch0Valid_i,  fetch1Valid_i;
  logic                fetch0Ready_o,  fetch1Ready_o;
  logic [BUNDLE_W-1:0] fetch0Bundle_i, fetch1Bundle_i;
  logic [ADDR_W-1:0]   fetch0Addr_i,   fetch1Addr_i;
  logic [1:0]          fetch0Len_i,    fetch1Len_i;
  logic                fetch0Is64_i,   fetch1Is64_i;
  logic [PID_W-1:0]    fetch0Pid_i,    fetch1Pid_i;
  logic [TID_W-1:0]    fetch0Tid_i,    fetch1Tid_i;
  logic                flush0_i,       flush1_i;
  logic [3:0]          decReady_i;

  logic                enable_o;
  logic [BUNDLE_W-1:0] bundle_o;
  logic [ADDR_W-1:0]   bundleAddress_o;
  logic [1:0]          bundleLen_o;
  logic                is64Bit_o;
  logic [PID_W-1:0]    bundlePid_o;
  logic [TID_W-1:0]    bundleTid_o;
  logic [CNT_W-1:0]    bundleStartMajId_o;
  logic                issuedThread_o;
`ifdef ISSUE_STATS_EN
  logic [31:0]         issued0Count_o, issued1Count_o, stall0Count_o, stall1Count_o;
`endif

  modport slave (
    input  fetch0Valid_i, fetch1Valid_i, fetch0Bundle_i, fetch1Bundle_i,
           fetch0Addr_i, fetch1Addr_i, fetch0Len_i, fetch1Len_i,
           fetch0Is64_i, fetch1Is64_i, fetch0Pid_i, fetch1Pid_i,
           fetch0Tid_i, fetch1Tid_i, flush0_i, flush1_i, decReady_i,
    output fetch0Ready_o, fetch1Ready_o, enable_o, bundle_o, bundleAddress_o,
           bundleLen_o, is64Bit_o, bundlePid_o, bundleTid_o,
           bundleStartMajId_o, issuedThread_o
`ifdef ISSUE_STATS_EN
    , output issued0Count_o, issued1Count_o, stall0Count_o, stall1Count_o
`endif
  );

  modport master (
    output fetch0Valid_i, fetch1Valid_i, fetch0Bundle_i, fetch1Bundle_i,
           fetch0Addr_i, fetch1Addr_i, fetch0Len_i, fetch1Len_i,
           fetch0Is64_i, fetch1Is64_i, fetch0Pid_i, fetch1Pid_i,
           fetch0Tid_i, fetch1Tid_i, flush0_i, flush1_i, decReady_i,
    input  fetch0Ready_o, fetch1Ready_o, enable_o, bundle_o, bundleAddress_o,
           bundleLen_o, is64Bit_o, bundlePid_o, bundleTid_o,
           bundleStartMajId_o, issuedThread_o
`ifdef ISSUE_STATS_EN
    , input issued0Count_o, issued1Count_o, stall0Count_o, stall1Count_o
`endif
  );

endinterface

// File: rtl/bundle_issue_scheduler_bundle_queue.sv
// Per-thread bundle FIFO. DEPTH must be a power of two >= 2 so the
// pointers wrap naturally. Flush empties the queue and beats a push.
module bundle_queue
  import bundle_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  logic     flush_i,
  input  q_entry_t entry_i,
  output q_entry_t head_o,
  output logic     empty_o,
  output logic     full_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  q_entry_t        mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push_s, do_pop_s;

  assign empty_o = (cnt_q == {CW{1'b0}});
  assign full_o  = (cnt_q == DEPTH_C);
  assign head_o  = mem_q[rd_q];

  // Pointer/count next state; flush clears everything and suppresses push/pop.
  always_comb begin
    do_push_s = push_i & ~full_o & ~flush_i;
    do_pop_s  = pop_i & ~empty_o & ~flush_i;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = {PW{1'b0}};
      wr_d  = {PW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else begin
      if (do_push_s) wr_d = wr_q + {{(PW-1){1'b0}}, 1'b1};
      else           wr_d = wr_q;
      if (do_pop_s)  rd_d = rd_q + {{(PW-1){1'b0}}, 1'b1};
      else           rd_d = rd_q;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q  <= {PW{1'b0}};
      wr_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_q] <= entry_i;
  end

endmodule

// File: rtl/bundle_issue_scheduler.sv
// Two-thread bundle issue scheduler: per-thread queues, round-robin pick
// gated by decoder readiness, registered issue, global major-ID counter.
// Optional statistics counters are built when ISSUE_STATS_EN is defined.
// majIdInit only moves the counter's reset value (normally 0).
module bundle_issue_scheduler
  import bundle_issue_scheduler_pkg::*;
#(
  parameter int unsigned      queueDepth = 2,
  parameter logic [CNT_W-1:0] majIdInit  = {CNT_W{1'b0}}
) (
  input logic                     clock_i,
  input logic                     reset_n_i,
  bundle_issue_scheduler_if.slave bus
);
  q_entry_t         entry0_s, entry1_s, head0_s, head1_s, sel_s;
  logic             empty0_s, empty1_s, full0_s, full1_s;
  logic             elig0_s, elig1_s, grant0_s, grant1_s;
  logic             last1_q, last1_d;   // 1 = thread 1 was granted last
  logic [CNT_W-1:0] maj_q, maj_d, start_q, start_d;
  q_entry_t         out_q, out_d;
  logic             enable_q, enable_d, thr_q, thr_d;

  assign entry0_s = '{bus.fetch0Bundle_i, bus.fetch0Addr_i, bus.fetch0Len_i,
                      bus.fetch0Is64_i, bus.fetch0Pid_i, bus.fetch0Tid_i};
  assign entry1_s = '{bus.fetch1Bundle_i, bus.fetch1Addr_i, bus.fetch1Len_i,
                      bus.fetch1Is64_i, bus.fetch1Pid_i, bus.fetch1Tid_i};

  bundle_queue #(.DEPTH(queueDepth)) u_q0 (
    .clk_i(clock_i), .rst_n_i(reset_n_i), .push_i(bus.fetch0Valid_i),
    .pop_i(grant0_s), .flush_i(bus.flush0_i), .entry_i(entry0_s),
    .head_o(head0_s), .empty_o(empty0_s), .full_o(full0_s));

  bundle_queue #(.DEPTH(queueDepth)) u_q1 (
    .clk_i(clock_i), .rst_n_i(reset_n_i), .push_i(bus.fetch1Valid_i),
    .pop_i(grant1_s), .flush_i(bus.flush1_i), .entry_i(entry1_s),
    .head_o(head1_s), .empty_o(empty1_s), .full_o(full1_s));

  assign bus.fetch0Ready_o = ~full0_s;
  assign bus.fetch1Ready_o = ~full1_s;

  // Eligibility and round-robin grant; on a tie the thread not granted last wins.
  always_comb begin
    elig0_s  = ~empty0_s & ~bus.flush0_i & dec_ready_ok(head0_s.len, bus.decReady_i);
    elig1_s  = ~empty1_s & ~bus.flush1_i & dec_ready_ok(head1_s.len, bus.decReady_i);
    grant0_s = elig0_s & (~elig1_s | last1_q);
    grant1_s = elig1_s & (~elig0_s | ~last1_q);
  end

  // Issue next state: load the granted head and advance the major-ID counter.
  always_comb begin
    sel_s    = grant1_s ? head1_s : head0_s;
    enable_d = 1'b0;
    out_d    = out_q;
    thr_d    = thr_q;
    start_d  = start_q;
    maj_d    = maj_q;
    last1_d  = last1_q;
    if (grant0_s || grant1_s) begin
      enable_d = 1'b1;
      out_d    = sel_s;
      thr_d    = grant1_s;
      last1_d  = grant1_s;
      start_d  = maj_q;
      maj_d    = maj_q + {{(CNT_W-2){1'b0}}, sel_s.len} + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      enable_d = 1'b0;
    end
  end

  // Registered issue outputs, counter and arbitration pointer.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      enable_q <= 1'b0;
      out_q    <= '0;
      thr_q    <= 1'b0;
      start_q  <= {CNT_W{1'b0}};
      maj_q    <= majIdInit;
      last1_q  <= 1'b1;
    end else begin
      enable_q <= enable_d;
      out_q    <= out_d;
      thr_q    <= thr_d;
      start_q  <= start_d;
      maj_q    <= maj_d;
      last1_q  <= last1_d;
    end
  end

  assign bus.enable_o           = enable_q;
  assign bus.bundle_o           = out_q.bundle;
  assign bus.bundleAddress_o    = out_q.addr;
  assign bus.bundleLen_o        = out_q.len;
  assign bus.is64Bit_o          = out_q.is64;
  assign bus.bundlePid_o        = out_q.pid;
  assign bus.bundleTid_o        = out_q.tid;
  assign bus.bundleStartMajId_o = start_q;
  assign bus.issuedThread_o     = thr_q;

`ifdef ISSUE_STATS_EN
  logic [31:0] iss0_q, iss1_q, stl0_q, stl1_q;

  // Saturating per-thread issue and stall counters.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      iss0_q <= 32'd0;
      iss1_q <= 32'd0;
      stl0_q <= 32'd0;
      stl1_q <= 32'd0;
    end else begin
      if (grant0_s) iss0_q <= sat_inc32(iss0_q);
      if (grant1_s) iss1_q <= sat_inc32(iss1_q);
      if (!empty0_s && !grant0_s) stl0_q <= sat_inc32(stl0_q);
      if (!empty1_s && !grant1_s) stl1_q <= sat_inc32(stl1_q);
    end
  end

  assign bus.issued0Count_o = iss0_q;
  assign bus.issued1Count_o = iss1_q;
  assign bus.stall0Count_o  = stl0_q;
  assign bus.stall1Count_o  = stl1_q;
`endif

endmodule
